imm_gen_pipe: RTL
=================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request present on instr/immsrc.
REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port instr  input  25  instruction bits [31:7]; bit 0 of the port carries instr bit 7.
REQ-007 SHALL have port immsrc  input  3  immediate format select.
REQ-008 SHALL have port out_valid  output  1  immext is valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts immext this cycle.
REQ-010 SHALL have port immext  output  XLEN  extended immediate, head of queue.
REQ-011 SHALL have port err  output  1  head entry used an illegal immsrc; present only with IMMGEN_ILLEGAL_EN.

Function
REQ-012 SHALL decode immsrc: 000 I = sext(instr[31:20]); 001 S = sext({instr[31:25],instr[11:7]}); 010 B = sext({instr[31],instr[7],instr[30:25],instr[11:8],0}).
REQ-013 SHALL decode immsrc: 011 J = sext({instr[31],instr[19:12],instr[20],instr[30:21],0}); 100 U = sext({instr[31:12],12'b0}); 101 Z = zext(instr[19:15]).
REQ-014 SHALL sign-extend from the immediate MSB to all XLEN bits; U-type with XLEN=64 SHALL replicate instr[31] into bits 63:32.
REQ-015 SHALL treat immsrc 110 and 111 as illegal: immediate value 0.
REQ-016 SHALL compute the immediate combinationally on input and store the result in a 2-entry FIFO; no decode on the output path.
REQ-017 SHALL accept a request on a clock edge where in_valid && in_ready (push).
REQ-018 SHALL pop the head on a clock edge where out_valid && out_ready.
REQ-019 SHALL drive in_ready = (count < 2); in_ready SHALL depend only on state, never combinationally on out_ready or in_valid.
REQ-020 SHALL drive out_valid = (count != 0); immext and err SHALL reflect the head entry.
REQ-021 SHALL give latency 1: a request pushed at edge N appears on immext after edge N, with out_valid high in cycle N+1.
REQ-022 SHALL update count by push-only +1, pop-only -1, and push+pop unchanged; order SHALL be strictly FIFO.
REQ-023 SHALL ignore in_valid while count = 2; the held request stays on the inputs until in_ready returns.
REQ-024 SHALL keep immext/err stable while out_valid && !out_ready.
REQ-025 SHALL wrap read/write pointers modulo 2.

Reset
REQ-026 SHALL, when reset is sampled high, clear count and pointers so that out_valid=0, in_ready=1, immext=0 and err=0 after that edge.
REQ-027 SHALL discard all queued entries on reset mid-operation; a push or pop coincident with reset SHALL be ignored.
REQ-028 SHALL hold in_ready at 1 during reset cycles, but no pushes SHALL be taken while reset is high.

Configuration
REQ-029 SHALL use macro IMMGEN_ILLEGAL_EN.
REQ-030 SHALL, with the macro defined, store a per-entry err bit, set for immsrc 110/111, and drive the err port from the head entry.
REQ-031 SHALL, without the macro, omit the err port and err storage; illegal codes SHALL still yield immext = 0.

Verification
REQ-032 SHALL check: XLEN=32, push instr=0xFE112E23>>7, immsrc=001 -> next cycle out_valid=1, immext=0xFFFFFFFC.
REQ-033 SHALL check: XLEN=32, push instr=0xFE000EE3>>7, immsrc=010 -> immext=0xFFFFFFFC; push instr=0xFFF00093>>7, immsrc=000 -> immext=0xFFFFFFFF.
REQ-034 SHALL check: XLEN=64, push instr=0x80000037>>7, immsrc=100 -> immext=0xFFFFFFFF80000000; push instr=0x123450B7>>7 -> immext=0x0000000012345000.
REQ-035 SHALL check: out_ready=0 with 3 back-to-back pushes -> in_ready low after the 2nd push; 3rd held; out_ready=1 -> all 3 emerge in order, one per cycle.
REQ-036 SHALL check: with IMMGEN_ILLEGAL_EN, immsrc=110 -> immext=0, err=1; the following legal entry shows err=0.
REQ-037 SHALL check: 2 entries queued, reset asserted 1 cycle -> out_valid=0, in_ready=1, queued entries never appear.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate decoder feeding a 2-entry output FIFO.
// Define IMMGEN_ILLEGAL_EN to add a per-entry err flag and the err port.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [24:0]     instr,
  input  logic [2:0]      immsrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] immext
`ifdef IMMGEN_ILLEGAL_EN
  ,
  output logic            err
`endif
);

  logic        s;
  logic [31:0] imm32;
  logic [XLEN-1:0] wide;

  assign s = instr[24];

  always_comb begin
    imm32 = '0;
    unique case (1'b1)
      (immsrc == 3'b000):
        imm32 = {{20{s}}, instr[24:13]};
      (immsrc == 3'b001):
        imm32 = {{20{s}}, instr[24:18], instr[4:0]};
      (immsrc == 3'b010):
        imm32 = {{20{s}}, instr[0], instr[23:18],
                 instr[4:1], 1'b0};
      (immsrc == 3'b011):
        imm32 = {{12{s}}, instr[12:5], instr[13],
                 instr[23:14], 1'b0};
      (immsrc == 3'b100):
        imm32 = {instr[24:5], 12'b0};
      (immsrc == 3'b101):
        imm32 = {27'b0, instr[12:8]};
      default:
        imm32 = '0;
    endcase
  end

  // every format fits a signed 32-bit value, so one
  // sign-extending cast covers both XLEN settings
  assign wide = XLEN'($signed(imm32));

  logic [XLEN-1:0] mem [2];
  logic            wptr;
  logic            rptr;
  logic [1:0]      count;
  logic            push;
  logic            pop;

  assign in_ready  = reset | ~count[1];
  assign out_valid = |count;
  assign push      = in_valid & ~count[1] & ~reset;
  assign pop       = out_valid & out_ready & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wide;
        wptr      <= ~wptr;
      end
      if (pop)
        rptr <= ~rptr;
      if (push && !pop)
        count <= count + 2'd1;
      else if (pop && !push)
        count <= count - 2'd1;
    end
  end

  assign immext = mem[rptr];

`ifdef IMMGEN_ILLEGAL_EN
  logic bad;
  logic errq [2];

  assign bad = immsrc[2] & immsrc[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      errq[0] <= 1'b0;
      errq[1] <= 1'b0;
    end else if (push) begin
      errq[wptr] <= bad;
    end
  end

  assign err = errq[rptr];
`endif

endmodule
